// File: rtl/led_actor_pkg.sv
// Shared definitions for the LED strip pipeline: sequencer states, pixel layout,
// latch timing at 12 MHz and the per-channel brightness scaling.
package led_actor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_LATCH  = 2'd2
    } seq_state_t;

    localparam int PIXEL_WIDTH = 24;
    localparam int R_OFS       = 16;
    localparam int G_OFS       = 8;
    localparam int B_OFS       = 0;
    localparam int INDEX_WIDTH = 9;

    localparam int CLOCK_HZ             = 12_000_000;
    localparam int LATCH_US             = 80;
    localparam int DEFAULT_LATCH_CYCLES = (CLOCK_HZ / 1_000_000) * LATCH_US;

    // (c * (b + 1)) >> 8: full scale is identity, zero blanks the channel.
    function automatic logic [7:0] scale_channel(input logic [7:0] c, input logic [7:0] b);
        logic [16:0] product;
        product = {9'd0, c} * ({9'd0, b} + 17'd1);
        return product[15:8];
    endfunction

endpackage

// File: rtl/pixel_scaler.sv
// Combinational brightness scaling of one {R,G,B} word followed by optional
// reordering to the {G,R,B} wire order of the strip.
module pixel_scaler
    import led_actor_pkg::*;
#(
    parameter bit GRB_ORDER = 1'b1
) (
    input  logic [7:0]             brightness,
    input  logic [PIXEL_WIDTH-1:0] pixel_in,
    output logic [PIXEL_WIDTH-1:0] pixel_out
);

    // scaled[0] = R, scaled[1] = G, scaled[2] = B
    logic [7:0] scaled [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_channel
            localparam int OFS = R_OFS - gi * 8;
            assign scaled[gi] = scale_channel(pixel_in[OFS +: 8], brightness);
        end
    endgenerate

    assign pixel_out = GRB_ORDER ? {scaled[1], scaled[0], scaled[2]}
                                 : {scaled[0], scaled[1], scaled[2]};

endmodule

// File: rtl/strip_frame_sequencer.sv
// Streams one strip's frame from LED memory to the serial encoder, prefetching
// one pixel ahead, then holds the line idle for the strip latch time.
module strip_frame_sequencer
    import led_actor_pkg::*;
#(
    parameter int LED_COUNT    = 60,
    parameter int ADDR_WIDTH   = 9,
    parameter int STRIP_BASE   = 0,
    parameter int LATCH_CYCLES = DEFAULT_LATCH_CYCLES,
    parameter bit GRB_ORDER    = 1'b1
) (
    input  logic                   clock_12mhz,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic [7:0]             brightness,
    output logic                   read_request,
    output logic [ADDR_WIDTH-1:0]  read_address,
    input  logic [PIXEL_WIDTH-1:0] read_data,
    input  logic                   read_data_valid,
    output logic                   encoder_start,
    output logic [PIXEL_WIDTH-1:0] encoder_data,
    input  logic                   encoder_done,
    output logic                   frame_busy,
    output logic                   frame_done,
    output logic                   frame_overrun
);

    localparam int LATCH_WIDTH = $clog2(LATCH_CYCLES + 1);
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(LED_COUNT);

    seq_state_t                 state_reg;
    logic [INDEX_WIDTH-1:0]     index_reg;
    logic [LATCH_WIDTH-1:0]     latch_count_reg;
    logic [7:0]                 brightness_reg;
    logic                       read_outstanding_reg;
    logic                       pending_valid_reg;
    logic                       encoder_active_reg;
    logic [PIXEL_WIDTH-1:0]     pending_reg;
    logic [PIXEL_WIDTH-1:0]     encoder_data_reg;
    logic [ADDR_WIDTH-1:0]      read_address_reg;
    logic                       read_request_reg;
    logic                       encoder_start_reg;
    logic                       frame_busy_reg;
    logic                       frame_done_reg;
    logic                       frame_overrun_reg;
    logic [PIXEL_WIDTH-1:0]     scaled_pixel;
    logic                       can_start;

    pixel_scaler #(
        .GRB_ORDER(GRB_ORDER)
    ) u_pixel_scaler (
        .brightness(brightness_reg),
        .pixel_in  (read_data),
        .pixel_out (scaled_pixel)
    );

    // A done in this cycle frees the encoder, so a pending pixel starts on the next cycle.
    assign can_start = (state_reg == ST_STREAM) && pending_valid_reg &&
                       (!encoder_active_reg || encoder_done);

    always_ff @(posedge clock_12mhz) begin
        if (reset) begin
            state_reg            <= ST_IDLE;
            index_reg            <= '0;
            latch_count_reg      <= '0;
            brightness_reg       <= '0;
            read_outstanding_reg <= 1'b0;
            pending_valid_reg    <= 1'b0;
            encoder_active_reg   <= 1'b0;
            pending_reg          <= '0;
            encoder_data_reg     <= '0;
            read_address_reg     <= '0;
            read_request_reg     <= 1'b0;
            encoder_start_reg    <= 1'b0;
            frame_busy_reg       <= 1'b0;
            frame_done_reg       <= 1'b0;
            frame_overrun_reg    <= 1'b0;
        end else begin
            read_request_reg  <= 1'b0;
            encoder_start_reg <= 1'b0;
            frame_done_reg    <= 1'b0;
            frame_overrun_reg <= 1'b0;

            if (read_data_valid && read_outstanding_reg) begin
                pending_reg          <= scaled_pixel;
                pending_valid_reg    <= 1'b1;
                read_outstanding_reg <= 1'b0;
            end

            if (encoder_done) begin
                encoder_active_reg <= 1'b0;
            end

            if (frame_start && state_reg != ST_IDLE) begin
                frame_overrun_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (frame_start) begin
                        brightness_reg       <= brightness;
                        index_reg            <= '0;
                        frame_busy_reg       <= 1'b1;
                        read_request_reg     <= 1'b1;
                        read_address_reg     <= ADDR_WIDTH'(STRIP_BASE);
                        read_outstanding_reg <= 1'b1;
                        state_reg            <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (can_start) begin
                        encoder_start_reg  <= 1'b1;
                        encoder_data_reg   <= pending_reg;
                        pending_valid_reg  <= 1'b0;
                        encoder_active_reg <= 1'b1;
                        index_reg          <= index_reg + 9'd1;
                        if (index_reg + 9'd1 < LAST_INDEX) begin
                            read_request_reg     <= 1'b1;
                            read_address_reg     <= ADDR_WIDTH'(STRIP_BASE) + ADDR_WIDTH'(index_reg + 9'd1);
                            read_outstanding_reg <= 1'b1;
                        end
                    end else if (index_reg == LAST_INDEX && encoder_active_reg && encoder_done) begin
                        latch_count_reg <= LATCH_WIDTH'(LATCH_CYCLES - 1);
                        state_reg       <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    if (latch_count_reg <= LATCH_WIDTH'(1)) begin
                        frame_done_reg <= 1'b1;
                        frame_busy_reg <= 1'b0;
                        state_reg      <= ST_IDLE;
                    end else begin
                        latch_count_reg <= latch_count_reg - LATCH_WIDTH'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign read_request  = read_request_reg;
    assign read_address  = read_address_reg;
    assign encoder_start = encoder_start_reg;
    assign encoder_data  = encoder_data_reg;
    assign frame_busy    = frame_busy_reg;
    assign frame_done    = frame_done_reg;
    assign frame_overrun = frame_overrun_reg;

endmodule

// File: tb/tb_strip_frame_sequencer.sv
// Randomized frame-level bench for strip_frame_sequencer with a 1-cycle memory
// model, an encoder model with configurable busy time and an arithmetic reference.
module tb_strip_frame_sequencer;

    localparam int LED_COUNT    = 3;
    localparam int ADDR_WIDTH   = 9;
    localparam int STRIP_BASE   = 16;
    localparam int LATCH_CYCLES = 960;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  frame_start = 1'b0;
    logic [7:0]            brightness = 8'd0;
    logic                  read_request;
    logic [ADDR_WIDTH-1:0] read_address;
    logic [23:0]           read_data;
    logic                  read_data_valid;
    logic                  encoder_start;
    logic [23:0]           encoder_data;
    logic                  encoder_done;
    logic                  frame_busy;
    logic                  frame_done;
    logic                  frame_overrun;

    strip_frame_sequencer #(
        .LED_COUNT   (LED_COUNT),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .STRIP_BASE  (STRIP_BASE),
        .LATCH_CYCLES(LATCH_CYCLES),
        .GRB_ORDER   (1'b1)
    ) dut (
        .clock_12mhz    (clk),
        .reset          (reset),
        .frame_start    (frame_start),
        .brightness     (brightness),
        .read_request   (read_request),
        .read_address   (read_address),
        .read_data      (read_data),
        .read_data_valid(read_data_valid),
        .encoder_start  (encoder_start),
        .encoder_data   (encoder_data),
        .encoder_done   (encoder_done),
        .frame_busy     (frame_busy),
        .frame_done     (frame_done),
        .frame_overrun  (frame_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [23:0] mem [512];
    int done_dly = 10;
    int spur_req_cnt = 0;
    int spur_done_cnt = 0;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor records
    int          fs_q[$];
    int          st_cyc_q[$];
    logic [23:0] st_data_q[$];
    logic [ADDR_WIDTH-1:0] addr_q[$];
    int          done_q[$];
    int          ovr_cnt = 0;
    int          busy_cnt = 0;
    int          glitch_cnt = 0;

    task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Reference pixel: integer arithmetic scaling, then {G,R,B} wire order.
    function automatic logic [23:0] ref_pixel(input logic [23:0] w, input logic [7:0] b);
        int k, r, g, bl;
        k  = int'(b) + 1;
        r  = (int'(w[23:16]) * k) / 256;
        g  = (int'(w[15:8]) * k) / 256;
        bl = (int'(w[7:0]) * k) / 256;
        return {g[7:0], r[7:0], bl[7:0]};
    endfunction

    // Memory (1-cycle read latency) and encoder (done after done_dly cycles) models.
    initial begin
        logic                  rd_pending;
        logic [ADDR_WIDTH-1:0] rd_addr;
        int                    done_at;
        rd_pending = 1'b0;
        rd_addr = '0;
        done_at = -1;
        read_data = '0;
        read_data_valid = 1'b0;
        encoder_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            read_data_valid = 1'b0;
            encoder_done = 1'b0;
            if (reset) begin
                rd_pending = 1'b0;
                done_at = -1;
            end else begin
                if (rd_pending) begin
                    read_data_valid = 1'b1;
                    read_data = mem[rd_addr];
                    rd_pending = 1'b0;
                end else if (spur_done_cnt < spur_req_cnt && !read_request) begin
                    read_data_valid = 1'b1;
                    read_data = 24'hA5C3E1;
                    spur_done_cnt++;
                end
                if (cyc == done_at) begin
                    encoder_done = 1'b1;
                    done_at = -1;
                end
                if (read_request) begin
                    rd_pending = 1'b1;
                    rd_addr = read_address;
                end
                if (encoder_start) done_at = cyc + done_dly;
            end
        end
    end

    initial begin
        logic [23:0] held;
        held = '0;
        forever begin
            @(negedge clk);
            if (reset) held = '0;
            if (frame_start) fs_q.push_back(cyc);
            if (encoder_start) begin
                st_cyc_q.push_back(cyc);
                st_data_q.push_back(encoder_data);
                held = encoder_data;
            end else if (encoder_data != held) begin
                glitch_cnt++;
            end
            if (read_request) addr_q.push_back(read_address);
            if (frame_done) done_q.push_back(cyc);
            if (frame_overrun) ovr_cnt++;
            if (frame_busy) busy_cnt++;
        end
    end

    task automatic pulse_start(input logic [7:0] br);
        @(posedge clk);
        #1;
        brightness = br;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        brightness = 8'($urandom);
    endtask

    task automatic run_frame(input int fid, input logic [7:0] br, input int dly,
                             input bit do_overrun, input bit do_spur);
        int s0, a0, d0, f0, o0, b0, g0, budget, fcyc, exp_cyc, n_st;
        s0 = st_cyc_q.size();
        a0 = addr_q.size();
        d0 = done_q.size();
        f0 = fs_q.size();
        o0 = ovr_cnt;
        b0 = busy_cnt;
        g0 = glitch_cnt;
        done_dly = dly;
        pulse_start(br);
        if (do_spur) spur_req_cnt++;
        if (do_overrun) begin
            repeat ($urandom_range(1, 60)) @(posedge clk);
            #1;
            frame_start = 1'b1;
            @(posedge clk);
            #1;
            frame_start = 1'b0;
        end
        budget = 0;
        while (done_q.size() == d0 && budget < 4000) begin
            @(posedge clk);
            budget++;
        end
        #1;
        check_value("frame_done_in_time", 32'(done_q.size() > d0), 32'd1);
        fcyc = fs_q[f0];
        n_st = st_cyc_q.size() - s0;
        check_value("start_count", 32'(n_st), 32'(LED_COUNT));
        check_value("read_count", 32'(addr_q.size() - a0), 32'(LED_COUNT));
        exp_cyc = fcyc + 4;
        for (int i = 0; i < LED_COUNT; i++) begin
            if (i < n_st) begin
                check_value($sformatf("px%0d_data", i), 32'(st_data_q[s0 + i]),
                            32'(ref_pixel(mem[STRIP_BASE + i], br)));
                check_value($sformatf("px%0d_start_cycle", i), 32'(st_cyc_q[s0 + i]), 32'(exp_cyc));
            end
            if (a0 + i < addr_q.size())
                check_value($sformatf("rd%0d_addr", i), 32'(addr_q[a0 + i]), 32'(STRIP_BASE + i));
            exp_cyc = exp_cyc + dly + 1;
        end
        if (done_q.size() > d0 && n_st > 0) begin
            check_value("frame_done_cycle", 32'(done_q[d0]), 32'(st_cyc_q[s0 + n_st - 1] + dly + LATCH_CYCLES));
            check_value("busy_cycles", 32'(busy_cnt - b0), 32'(done_q[d0] - fcyc - 1));
        end
        check_value("overrun_count", 32'(ovr_cnt - o0), 32'(do_overrun));
        check_value("data_stable", 32'(glitch_cnt - g0), 32'd0);
        $display("frame %0d: br=%0d dly=%0d overrun=%0d spur=%0d starts=%0d", fid, br, dly,
                 do_overrun, do_spur, n_st);
    endtask

    initial begin
        int s0, budget;
        logic [7:0] br;
        for (int i = 0; i < 512; i++) mem[i] = 24'($urandom);

        repeat (3) @(posedge clk);
        #1;
        check_value("reset_read_request", 32'(read_request), 32'd0);
        check_value("reset_read_address", 32'(read_address), 32'd0);
        check_value("reset_encoder_start", 32'(encoder_start), 32'd0);
        check_value("reset_encoder_data", 32'(encoder_data), 32'd0);
        check_value("reset_frame_busy", 32'(frame_busy), 32'd0);
        check_value("reset_frame_done", 32'(frame_done), 32'd0);
        check_value("reset_frame_overrun", 32'(frame_overrun), 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Basic frame at full brightness
        mem[STRIP_BASE + 0] = 24'h112233;
        mem[STRIP_BASE + 1] = 24'h445566;
        mem[STRIP_BASE + 2] = 24'h778899;
        s0 = st_data_q.size();
        run_frame(0, 8'd255, 100, 1'b0, 1'b0);
        check_value("basic_px0", 32'(st_data_q[s0 + 0]), 32'h221133);
        check_value("basic_px1", 32'(st_data_q[s0 + 1]), 32'h554466);
        check_value("basic_px2", 32'(st_data_q[s0 + 2]), 32'h887799);

        // Scaling corner values
        mem[STRIP_BASE] = 24'hFF8000;
        s0 = st_data_q.size();
        run_frame(1, 8'd127, 5, 1'b0, 1'b0);
        check_value("scale_127", 32'(st_data_q[s0]), 32'h407F00);
        s0 = st_data_q.size();
        run_frame(2, 8'd0, 5, 1'b0, 1'b0);
        check_value("scale_0", 32'(st_data_q[s0]), 32'h000000);

        // Overrun and spurious read data, shortest encoder time
        run_frame(3, 8'd200, 2, 1'b1, 1'b0);
        run_frame(4, 8'd90, 2, 1'b0, 1'b1);

        // Spurious read data while idle must not produce a start
        s0 = st_cyc_q.size();
        spur_req_cnt++;
        repeat (20) @(posedge clk);
        #1;
        check_value("idle_spurious_no_start", 32'(st_cyc_q.size()), 32'(s0));

        // Reset after the second start
        s0 = st_cyc_q.size();
        done_dly = 30;
        pulse_start(8'd255);
        budget = 0;
        while (st_cyc_q.size() < s0 + 2 && budget < 500) begin
            @(posedge clk);
            budget++;
        end
        check_value("midreset_two_starts", 32'(st_cyc_q.size() >= s0 + 2), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_value("midreset_read_request", 32'(read_request), 32'd0);
        check_value("midreset_read_address", 32'(read_address), 32'd0);
        check_value("midreset_encoder_start", 32'(encoder_start), 32'd0);
        check_value("midreset_encoder_data", 32'(encoder_data), 32'd0);
        check_value("midreset_frame_busy", 32'(frame_busy), 32'd0);
        reset = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        check_value("midreset_no_more_starts", 32'(st_cyc_q.size()), 32'(s0 + 2));

        // Randomized frames
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < LED_COUNT; i++) mem[STRIP_BASE + i] = 24'($urandom);
            case ($urandom_range(0, 3))
                0: br = 8'd255;
                1: br = 8'd0;
                default: br = 8'($urandom);
            endcase
            run_frame(5 + f, br, int'($urandom_range(2, 40)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/strip_frame_sequencer.md
Name: strip_frame_sequencer

Overview:
- Downstream of the LED memory and upstream of encoder_xx6812. Streams one strip's frame out of RAM, one LED at a time.
- On each frame trigger it reads LED_COUNT pixels from memory and applies global brightness scaling and RGB->GRB reordering.
- It hands each pixel to the encoder with a start/done handshake. It prefetches one pixel so the encoder never waits, then holds the line idle for the strip latch time.

Parameters:
- LED_COUNT, 60, LEDs per frame (1..256).
- ADDR_WIDTH, 9, memory read address width.
- STRIP_BASE, 0, first memory address of this strip.
- LATCH_CYCLES, 960, idle cycles after the last LED (80 us at 12 MHz).
- GRB_ORDER, 1, 1: output {G,R,B}; 0: output {R,G,B} unchanged.

Ports:
- clock_12mhz  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle frame trigger (framerate tick).
- brightness  in  8  global brightness, sampled on the accepted frame_start.
- read_request  out  1  one-cycle memory read strobe.
- read_address  out  ADDR_WIDTH  STRIP_BASE + led index.
- read_data  in  24  memory word {R[23:16],G[15:8],B[7:0]}.
- read_data_valid  in  1  one-cycle pulse, read_data valid.
- encoder_start  out  1  one-cycle pulse, load encoder_data.
- encoder_data  out  24  scaled, reordered pixel; stable from start until the next start.
- encoder_done  in  1  one-cycle pulse, encoder finished 24 bits.
- frame_busy  out  1  high from the accepted frame_start until the latch ends.
- frame_done  out  1  one-cycle pulse at the end of the latch.
- frame_overrun  out  1  one-cycle pulse when frame_start arrives while busy.

Behaviour:
- Reset values: every output 0, state IDLE, index 0, pending_valid 0, encoder_active 0. Reset mid-frame drops the pending pixel and issues no further start.
- States:
  - IDLE: on frame_start, latch brightness, set index=0 and frame_busy=1, go to STREAM. In the next cycle, read_request=1 with read_address=STRIP_BASE.
  - STREAM: operates per the rules below.
  - LATCH: count LATCH_CYCLES cycles. On the final count, pulse frame_done, clear frame_busy, go to IDLE.
- Pixel path:
  - read_data_valid with a read outstanding produces a pixel_scaler result registered into the pending register next cycle; set pending_valid.
  - read_data_valid with no read outstanding is ignored.
- Start rule, evaluated on registered state: if pending_valid=1 and encoder_active=0, then in one cycle:
  - encoder_start=1, encoder_data<=pending, pending_valid<=0, encoder_active<=1, index++;
  - if LEDs remain unrequested, issue the next read_request in the same cycle (prefetch).
- encoder_done clears encoder_active. If a pixel is pending, its start occurs the cycle after done, never in the same cycle.
- Sent count reaching LED_COUNT plus encoder_done of the last LED moves to LATCH.
- At most one read outstanding and one pixel pending at any time.
- frame_start in any state other than IDLE pulses frame_overrun and is otherwise ignored.
- Latency at 1-cycle memory: frame_start@t -> read_request@t+1 -> read_data_valid@t+2 -> pending@t+3 -> encoder_start@t+4.
- Scaling, per 8-bit channel c: out = (c * (brightness+1)) >> 8, 17-bit product truncated to 8 bits. brightness=255 gives identity; 0 gives 0.
- Reorder applies after scaling, per GRB_ORDER.
- Index counter width is 9 bits; no wrap within a frame. LED_COUNT=1 works: one read, one start, then LATCH.

Decomposition:
- Shared header/package (led_actor_pkg) holds:
  - state encodings (IDLE/STREAM/LATCH);
  - PIXEL_WIDTH=24;
  - channel byte offsets R=16, G=8, B=0;
  - 12 MHz latch default.
- One sub-module, pixel_scaler: purely combinational three-channel multiply/shift plus GRB reorder, instantiated once.

Test Plan:
- Basic frame: LED_COUNT=3, brightness=255, mem[0..2]=0x112233,0x445566,0x778899, encoder_done 100 cycles after each start -> encoder_data 0x221133, 0x554466, 0x887799 in order; exactly 3 starts; frame_done 960 cycles after the third done.
- Scaling: brightness=127, mem[0]=0xFF8000 -> encoder_data 0x407F00. Brightness=0 -> 0x000000.
- Prefetch/timing: frame_start@t -> read_request@t+1 addr STRIP_BASE, encoder_start@t+4. Second read_request (address 1) coincides with the first encoder_start.
- Overrun: frame_start pulsed while frame_busy=1 -> frame_overrun pulse, addresses and start count unchanged. Spurious read_data_valid with no read outstanding -> no pending pixel.
- Back-to-back: encoder_done arrives with a pixel pending -> next encoder_start exactly one cycle later, no gaps across all LED_COUNT LEDs.
- Reset mid-frame: reset asserted after the second start -> all outputs 0 next cycle, no further starts. A new frame_start restarts at STRIP_BASE.
